ysyx_24070017_rf_wb_ctrl: RTL and testbench

//  Write-back and read-access controller that drives the flat register-file bus (per-slot write enables,

---
 rtl/ysyx_24070017_rf_wb_ctrl.sv | 126 ++++++++++++
 tb/tb_ysyx_24070017_rf_wb_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24070017_rf_wb_ctrl.sv
// Write-back / read-access controller for the flat register-file bus: an in-order write queue
// drains one entry per cycle into the RF, and a one-deep response register serves rs1/rs2 reads.
module ysyx_24070017_rf_wb_ctrl #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned WQ_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wb_valid,
   output logic                 wb_ready,
   input  logic [AW-1:0]        wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 wq_hold,
   output logic                 wq_empty,
   input  logic                 rd_req_valid,
   output logic                 rd_req_ready,
   input  logic [AW-1:0]        rs1,
   input  logic [AW-1:0]        rs2,
   output logic                 rd_resp_valid,
   input  logic                 rd_resp_ready,
   output logic [XLEN-1:0]      rs1_data,
   output logic [XLEN-1:0]      rs2_data,
   output logic [NREG*XLEN-1:0] rf_wdata,
   output logic [NREG-1:0]      rf_we,
   input  logic [NREG*XLEN-1:0] rf_rdata
);

   localparam int unsigned PW = $clog2(WQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]   q_rd_q   [WQ_DEPTH];
   logic [XLEN-1:0] q_data_q [WQ_DEPTH];
   logic [PW:0]     wptr_q, rptr_q;
   logic [PW:0]     occ;
   logic [PW-1:0]   widx, ridx;
   logic            empty, full;
   logic            wb_fire, push, pop, rd_fire;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;

   assign widx     = wptr_q[PW-1:0];
   assign ridx     = rptr_q[PW-1:0];
   assign occ      = wptr_q - rptr_q;
   assign empty    = (wptr_q == rptr_q);
   assign full     = (widx == ridx) && (wptr_q[PW] != rptr_q[PW]);
   assign wb_ready = !full;
   assign wq_empty = empty;
   assign wb_fire  = wb_valid && !full;
   // Writes to x0 complete the handshake but never occupy a queue slot.
   assign push     = wb_fire && (wb_rd != '0);
   assign pop      = !empty && !wq_hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
            q_rd_q[i]   <= '0;
            q_data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            q_rd_q[widx]   <= wb_rd;
            q_data_q[widx] <= wb_data;
         end
         wptr_q <= wptr_q + {{PW{1'b0}}, push};
         rptr_q <= rptr_q + {{PW{1'b0}}, pop};
      end
   end

   assign rf_wdata = {NREG{q_data_q[ridx]}};

   always_comb begin
      rf_we = '0;
      if (pop && (q_rd_q[ridx] != '0)) rf_we[q_rd_q[ridx]] = 1'b1;
   end

   // Youngest match wins: walk oldest to youngest so later hits overwrite earlier ones.
   function automatic logic [XLEN-1:0] read_operand(input logic [AW-1:0] addr);
      logic [XLEN-1:0] val;
      logic [PW-1:0]   slot;
      val = rf_rdata[XLEN*int'(addr) +: XLEN];
      for (int unsigned i = 0; i < WQ_DEPTH; i++) begin
         slot = ridx + PW'(i);
         if ((CW'(i) < occ) && (q_rd_q[slot] == addr)) val = q_data_q[slot];
      end
      if (wb_fire && (wb_rd == addr)) val = wb_data;
      if (addr == '0) val = '0;
      return val;
   endfunction

   assign rd_req_ready = !resp_valid_q || rd_resp_ready;
   assign rd_fire      = rd_req_valid && rd_req_ready;

   always_comb begin
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      resp_valid_d = resp_valid_q;
      if (rd_fire) begin
         rs1_d        = read_operand(rs1);
         rs2_d        = read_operand(rs2);
         resp_valid_d = 1'b1;
      end else if (rd_resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid_q <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
      end
   end

   assign rd_resp_valid = resp_valid_q;
   assign rs1_data      = rs1_q;
   assign rs2_data      = rs2_q;

endmodule

// File: tb/tb_ysyx_24070017_rf_wb_ctrl.sv
// Bench for ysyx_24070017_rf_wb_ctrl: an architectural register model plus expected-write and
// expected-response queues, checked by a negedge monitor against the DUT.
module tb_ysyx_24070017_rf_wb_ctrl;

   localparam int XLEN     = 32;
   localparam int NREG     = 32;
   localparam int AW       = 5;
   localparam int WQ_DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 wb_valid = 1'b0;
   logic                 wb_ready;
   logic [AW-1:0]        wb_rd = '0;
   logic [XLEN-1:0]      wb_data = '0;
   logic                 wq_hold = 1'b0;
   logic                 wq_empty;
   logic                 rd_req_valid = 1'b0;
   logic                 rd_req_ready;
   logic [AW-1:0]        rs1 = '0;
   logic [AW-1:0]        rs2 = '0;
   logic                 rd_resp_valid;
   logic                 rd_resp_ready = 1'b1;
   logic [XLEN-1:0]      rs1_data, rs2_data;
   logic [NREG*XLEN-1:0] rf_wdata;
   logic [NREG-1:0]      rf_we;
   logic [NREG*XLEN-1:0] rf_rdata;
   logic                 rf_init = 1'b1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_24070017_rf_wb_ctrl #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .WQ_DEPTH(WQ_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wq_hold(wq_hold), .wq_empty(wq_empty),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rs1(rs1), .rs2(rs2),
      .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata)
   );

   // Register file the controller talks to; slot 0 reads as zero.
   logic [XLEN-1:0] rf_mem [NREG];
   for (genvar g = 0; g < NREG; g++) begin : g_rf
      assign rf_rdata[g*XLEN +: XLEN] = (g == 0) ? '0 : rf_mem[g];
   end
   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rf_init) rf_mem[i] <= $urandom;
         else if (rf_we[i]) rf_mem[i] <= rf_wdata[i*XLEN +: XLEN];
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: arch holds program-order register state; exp_wr lists accepted writes
   // not yet seen on the RF bus; exp_rsp holds the outstanding read response.
   typedef struct packed { logic [AW-1:0] rd; logic [XLEN-1:0] data; } wr_t;
   typedef struct packed { logic [XLEN-1:0] a; logic [XLEN-1:0] b; } rsp_t;
   wr_t             exp_wr[$];
   rsp_t            exp_rsp[$];
   logic [XLEN-1:0] arch [NREG];

   always @(negedge clk) begin : monitor
      wr_t  w;
      rsp_t r;
      logic wb_acc, rd_acc, drain;
      if (!rst) begin
         for (int i = 0; i < NREG; i++) arch[i] = rf_mem[i];
         arch[0] = '0;
         exp_wr.delete();
         exp_rsp.delete();
      end else begin
         wb_acc = wb_valid && (exp_wr.size() < WQ_DEPTH);
         rd_acc = rd_req_valid && ((exp_rsp.size() == 0) || rd_resp_ready);
         drain  = (exp_wr.size() > 0) && !wq_hold;
         check("wq_empty", wq_empty, exp_wr.size() == 0);
         check("wb_ready", wb_ready, exp_wr.size() < WQ_DEPTH);
         check("rd_req_ready", rd_req_ready, (exp_rsp.size() == 0) || rd_resp_ready);
         check("rd_resp_valid", rd_resp_valid, exp_rsp.size() != 0);
         if (drain) begin
            w = exp_wr.pop_front();
            check("rf_we_drain", rf_we, 64'(1) << w.rd);
            check("rf_wdata_slot", rf_wdata[int'(w.rd)*XLEN +: XLEN], w.data);
            check("rf_wdata_slot0", rf_wdata[XLEN-1:0], w.data);
         end else begin
            check("rf_we_idle", rf_we, 0);
         end
         if (exp_rsp.size() > 0) begin
            r = exp_rsp[0];
            check("rs1_data", rs1_data, r.a);
            check("rs2_data", rs2_data, r.b);
            if (rd_resp_ready) void'(exp_rsp.pop_front());
         end
         if (wb_acc && (wb_rd != '0)) begin
            arch[wb_rd] = wb_data;
            exp_wr.push_back('{rd: wb_rd, data: wb_data});
         end
         if (rd_acc) exp_rsp.push_back('{a: arch[rs1], b: arch[rs2]});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid      = 1'b0;
      rd_req_valid  = 1'b0;
      rd_resp_ready = 1'b1;
      wq_hold       = 1'b0;
   endtask

   task automatic wb(input int rd, input logic [XLEN-1:0] data);
      wb_valid = 1'b1;
      wb_rd    = AW'(rd);
      wb_data  = data;
   endtask

   task automatic rd(input int a, input int b);
      rd_req_valid = 1'b1;
      rs1          = AW'(a);
      rs2          = AW'(b);
   endtask

   initial begin
      int waited;
      // Reset: RF contents randomised, controller held in reset.
      repeat (2) @(posedge clk);
      #1 rf_init = 1'b0;
      check("rst_wq_empty", wq_empty, 1);
      check("rst_resp_valid", rd_resp_valid, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_rs1", rs1_data, 0);
      check("rst_rs2", rs2_data, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick(1);

      // 1: single write, one-cycle latency to rf_we, RF updated at the following edge.
      wb(5, 32'hDEADBEEF);
      tick(1);
      wb_valid = 1'b0;
      check("t1_rf_we", rf_we, 64'h20);
      tick(1);
      check("t1_rf_x5", rf_mem[5], 32'hDEADBEEF);
      check("t1_empty", wq_empty, 1);

      // 2: fill the queue under hold, then drain in order.
      wq_hold = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wb(i, $urandom);
         tick(1);
      end
      wb_valid = 1'b0;
      check("t2_full_ready", wb_ready, 0);
      check("t2_not_empty", wq_empty, 0);
      wq_hold = 1'b0;
      tick(4);
      check("t2_drained", wq_empty, 1);

      // 3: youngest queued write wins; x0 reads zero.
      wq_hold = 1'b1;
      wb(7, 32'd1);
      tick(1);
      wb(7, 32'd2);
      tick(1);
      wb_valid = 1'b0;
      rd(7, 0);
      tick(1);
      rd_req_valid = 1'b0;
      check("t3_valid", rd_resp_valid, 1);
      check("t3_rs1", rs1_data, 32'd2);
      check("t3_rs2", rs2_data, 0);
      wq_hold = 1'b0;
      tick(3);

      // 4: same-cycle write forwarding, then a write to x0.
      wb(9, 32'h55);
      rd(9, 5);
      tick(1);
      wb_valid     = 1'b0;
      rd_req_valid = 1'b0;
      check("t4_rs1", rs1_data, 32'h55);
      check("t4_rs2", rs2_data, 32'hDEADBEEF);
      tick(2);
      wb(0, 32'h1234);
      check("t4_x0_ready", wb_ready, 1);
      tick(1);
      wb_valid = 1'b0;
      check("t4_x0_we", rf_we, 0);
      check("t4_x0_empty", wq_empty, 1);
      tick(1);
      check("t4_x0_we2", rf_we, 0);

      // 5: response back-pressure, then full-throughput reads.
      rd_resp_ready = 1'b0;
      rd(3, 4);
      tick(1);
      rd(1, 2);
      for (int i = 0; i < 2; i++) begin
         check("t5_stall_ready", rd_req_ready, 0);
         check("t5_hold_rs1", rs1_data, rf_mem[3]);
         check("t5_hold_rs2", rs2_data, rf_mem[4]);
         tick(1);
      end
      rd_resp_ready = 1'b1;
      tick(1);
      for (int k = 0; k < 4; k++) begin
         rd(k + 10, k + 20);
         check("t5_stream_ready", rd_req_ready, 1);
         tick(1);
         check("t5_stream_valid", rd_resp_valid, 1);
      end
      rd_req_valid = 1'b0;
      tick(2);

      // 6: asynchronous reset with queued writes and a pending response.
      wq_hold = 1'b1;
      for (int i = 11; i <= 13; i++) begin
         wb(i, $urandom);
         tick(1);
      end
      wb_valid      = 1'b0;
      rd_resp_ready = 1'b0;
      rd(11, 12);
      tick(1);
      rd_req_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("t6_empty", wq_empty, 1);
      check("t6_resp_valid", rd_resp_valid, 0);
      check("t6_rf_we", rf_we, 0);
      check("t6_rs1", rs1_data, 0);
      idle();
      @(posedge clk);
      #1 rst = 1'b1;
      tick(1);

      // Randomised traffic checked by the monitor.
      repeat (2000) begin
         wb_valid      = ($urandom_range(0, 99) < 60);
         wb_rd         = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                                     : AW'($urandom_range(0, 7));
         wb_data       = $urandom;
         wq_hold       = ($urandom_range(0, 99) < 25);
         rd_req_valid  = ($urandom_range(0, 99) < 60);
         rs1           = AW'($urandom_range(0, 7));
         rs2           = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                                     : AW'($urandom_range(0, NREG - 1));
         rd_resp_ready = ($urandom_range(0, 99) < 70);
         tick(1);
      end

      // Drain everything and compare the final RF against the architectural model.
      idle();
      waited = 0;
      while ((!wq_empty || rd_resp_valid) && waited < 50) begin
         tick(1);
         waited++;
      end
      check("drain_done", wq_empty && !rd_resp_valid, 1);
      tick(2);
      check("final_wr_queue", exp_wr.size(), 0);
      for (int i = 1; i < NREG; i++) check("final_rf", rf_mem[i], arch[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
